// File: rtl/spi_pkg.sv
// Shared SPI definitions: transfer width and the slave/master link-state encoding.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop bit synchronizer for an asynchronous input, with a configurable reset value.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_reg <= {STAGES{RST_VAL}};
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0, MSB-first slave with a one-deep transmit holding register.
// Optional sticky receive-overrun flag when SPI_SLAVE_OVERRUN_EN is defined.
module spi_slave
  import spi_pkg::*;
#(
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = 8'hFF,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SCK_I,
  input  logic                  SS_I,
  input  logic                  IO0_I,
  output logic                  IO1_O,
  output logic                  IO1_T,
  input  logic [SPI_BYTE_W-1:0] spi_tx_data,
  input  logic                  spi_tx_valid,
  output logic                  spi_tx_ready,
  output logic [SPI_BYTE_W-1:0] spi_rx_data,
`ifdef SPI_SLAVE_OVERRUN_EN
  output logic                  spi_rx_overrun,
`endif
  output logic                  spi_rx_valid
);

  localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);

  logic sck_s, ss_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst(rst), .d(SCK_I), .q(sck_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
    .clk(clk), .rst(rst), .d(SS_I), .q(ss_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(IO0_I), .q(mosi_s)
  );

  spi_state_t              state_reg, state_next;
  logic                    sck_prev_reg, ss_prev_reg;
  logic                    armed_reg;
  logic [FLUSH_W-1:0]      flush_cnt_reg;
  logic [2:0]              bit_cnt_reg;
  logic [SPI_BYTE_W-1:0]   tx_shift_reg, rx_shift_reg;
  logic [SPI_BYTE_W-1:0]   hold_data_reg, rx_data_reg;
  logic                    hold_full_reg, rx_valid_reg;

  logic                    flush_done, sck_rise, sck_fall, ss_fall, ss_rise;
  logic                    active, start, abort, shift_in, shift_out, reload;
  logic                    tx_load, tx_hs, byte_done;
  logic [SPI_BYTE_W-1:0]   load_byte, rx_byte;

  // After reset the SS synchronizer holds its idle value for a few cycles; a frame
  // may only start once SS has genuinely been seen high, so a select left low
  // across reset never looks like a fresh fall.
  assign flush_done = (flush_cnt_reg == FLUSH_W'(SYNC_STAGES));
  assign sck_rise   = sck_s & ~sck_prev_reg;
  assign sck_fall   = ~sck_s & sck_prev_reg;
  assign ss_fall    = armed_reg & ss_prev_reg & ~ss_s;
  assign ss_rise    = ss_s & ~ss_prev_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (ss_fall) state_next = ACTIVE;
      ACTIVE:  state_next = ACTIVE;
      default: state_next = IDLE;
    endcase
    if (ss_rise) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  assign active    = (state_reg == ACTIVE);
  assign start     = (state_reg == IDLE) && (state_next == ACTIVE);
  assign abort     = active && ss_rise;
  assign shift_in  = active && sck_rise && !ss_rise;
  assign shift_out = active && sck_fall && !ss_rise;
  // The falling edge that follows the eighth rising edge starts the next byte.
  assign reload    = shift_out && (bit_cnt_reg == 3'd0);
  assign tx_load   = start || reload;
  assign load_byte = hold_full_reg ? hold_data_reg : IDLE_BYTE;
  assign byte_done = shift_in && (bit_cnt_reg == 3'd7);
  assign rx_byte   = {rx_shift_reg[SPI_BYTE_W-2:0], mosi_s};
  assign tx_hs     = spi_tx_valid && spi_tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_prev_reg  <= 1'b0;
      ss_prev_reg   <= 1'b1;
      armed_reg     <= 1'b0;
      flush_cnt_reg <= '0;
      bit_cnt_reg   <= 3'd0;
      tx_shift_reg  <= '0;
      rx_shift_reg  <= '0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
    end else begin
      sck_prev_reg <= sck_s;
      ss_prev_reg  <= ss_s;
      rx_valid_reg <= 1'b0;

      if (!flush_done) flush_cnt_reg <= flush_cnt_reg + FLUSH_W'(1);
      if (flush_done && ss_s) armed_reg <= 1'b1;

      if (tx_load) begin
        tx_shift_reg <= load_byte;
      end else if (shift_out) begin
        tx_shift_reg <= {tx_shift_reg[SPI_BYTE_W-2:0], 1'b0};
      end

      if (start || abort) begin
        bit_cnt_reg  <= 3'd0;
        rx_shift_reg <= '0;
      end else if (shift_in) begin
        bit_cnt_reg  <= bit_cnt_reg + 3'd1;
        rx_shift_reg <= rx_byte;
      end

      if (byte_done) begin
        rx_data_reg  <= rx_byte;
        rx_valid_reg <= 1'b1;
      end
    end
  end

  // Holding register: a load consumes the old byte while a same-cycle
  // handshake (only possible when it was empty) deposits the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full_reg <= 1'b0;
      hold_data_reg <= '0;
    end else begin
      if (tx_load && hold_full_reg) hold_full_reg <= 1'b0;
      if (tx_hs) begin
        hold_data_reg <= spi_tx_data;
        hold_full_reg <= 1'b1;
      end
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_unread_reg, rx_overrun_reg;

  // A tx handshake is taken as the host's acknowledgement of the last rx byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_unread_reg  <= 1'b0;
      rx_overrun_reg <= 1'b0;
    end else begin
      if (byte_done)  rx_unread_reg <= 1'b1;
      else if (tx_hs) rx_unread_reg <= 1'b0;
      if (byte_done && rx_unread_reg && !tx_hs) rx_overrun_reg <= 1'b1;
    end
  end

  assign spi_rx_overrun = rx_overrun_reg;
`endif

  assign IO1_O        = tx_shift_reg[SPI_BYTE_W-1];
  assign IO1_T        = ~active;
  assign spi_tx_ready = ~hold_full_reg & ~rst;
  assign spi_rx_data  = rx_data_reg;
  assign spi_rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: behavioural SPI master plus a byte-slot queue model.
`timescale 1ns/1ps
module tb_spi_slave;

  localparam logic [7:0] IDLE_B = 8'hFF;
  localparam int         SYNC   = 2;
  localparam int         HP     = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic       io1_o, io1_t;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       spi_tx_ready;
  logic [7:0] spi_rx_data;
  logic       spi_rx_valid;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       rx_overrun;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_got[$];
  logic [7:0] frame_mo [0:3];
  logic [7:0] frame_pv [0:4];
  bit         frame_push [0:4];

  always #4 clk = ~clk;

  spi_slave #(.IDLE_BYTE(IDLE_B), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .SCK_I(sck), .SS_I(ss), .IO0_I(mosi),
    .IO1_O(io1_o), .IO1_T(io1_t),
    .spi_tx_data(tx_data), .spi_tx_valid(tx_valid), .spi_tx_ready(spi_tx_ready),
    .spi_rx_data(spi_rx_data),
`ifdef SPI_SLAVE_OVERRUN_EN
    .spi_rx_overrun(rx_overrun),
`endif
    .spi_rx_valid(spi_rx_valid)
  );

  always @(negedge clk) if (spi_rx_valid) rx_got.push_back(spi_rx_data);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] slot_byte();
    if (exp_q.size() > 0) return exp_q.pop_front();
    return IDLE_B;
  endfunction

  task automatic push_byte(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (!spi_tx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("tx_accept", spi_tx_ready, 1'b1);
    @(negedge clk);
    tx_valid = 1'b0;
    if (n < 50) exp_q.push_back(d);
    $display("[TB] push tx=%02h", d);
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      @(negedge clk);
      mosi = mo[7-b];
      repeat (HP) @(negedge clk);
      mi  = {mi[6:0], io1_o};
      sck = 1'b1;
      repeat (HP) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic run_frame(input int n);
    logic [7:0] cur, mi;
    if (frame_push[0]) push_byte(frame_pv[0]);
    @(negedge clk);
    ss  = 1'b0;
    cur = slot_byte();
    repeat (SYNC + 2) @(negedge clk);
    check("frame_t", io1_t, 1'b0);
    check("frame_msb", io1_o, cur[7]);
    for (int k = 0; k < n; k++) begin
      fork
        spi_bits(frame_mo[k], 8, mi);
        begin
          if (frame_push[k+1]) begin
            repeat (20) @(negedge clk);
            push_byte(frame_pv[k+1]);
          end
        end
      join
      $display("[TB] byte mosi=%02h miso=%02h", frame_mo[k], mi);
      check("miso", mi, cur);
      check("rx_cnt", rx_got.size(), 1);
      if (rx_got.size() > 0) check("rx_data", rx_got[0], frame_mo[k]);
      rx_got.delete();
      cur = slot_byte();
    end
    repeat (HP) @(negedge clk);
    ss = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 5; i++) begin
      frame_push[i] = 1'b0;
      frame_pv[i]   = 8'h00;
    end
  endtask

  initial begin
    logic [7:0] mi;
    int nb;

    repeat (4) @(negedge clk);
    check("rst_t", io1_t, 1'b1);
    check("rst_o", io1_o, 1'b0);
    check("rst_ready", spi_tx_ready, 1'b0);
    check("rst_valid", spi_rx_valid, 1'b0);
    check("rst_rxdata", spi_rx_data, 8'h00);
    rst = 1'b0;
    #1;
    check("ready_after_rst", spi_tx_ready, 1'b1);
    repeat (12) @(negedge clk);

    // Single byte: master 55, slave 3C queued.
    clear_frame();
    frame_mo[0] = 8'h55; frame_push[0] = 1'b1; frame_pv[0] = 8'h3C;
    run_frame(1);

    // Three-byte frame with just-in-time queueing; third byte falls back to IDLE.
    clear_frame();
    frame_mo[0] = 8'hA3; frame_mo[1] = 8'hAA; frame_mo[2] = 8'h01;
    frame_push[0] = 1'b1; frame_pv[0] = 8'h11;
    frame_push[1] = 1'b1; frame_pv[1] = 8'h22;
    run_frame(3);

    // Abort after two bits: loaded byte is lost, a later-queued byte survives.
    push_byte(8'h5A);
    @(negedge clk);
    ss = 1'b0;
    void'(slot_byte());
    spi_bits(8'hF0, 2, mi);
    push_byte(8'h6B);
    @(negedge clk);
    ss = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    check("abort_t", io1_t, 1'b1);
    repeat (12) @(negedge clk);
    check("abort_no_rx", rx_got.size(), 0);
    rx_got.delete();
    clear_frame();
    frame_mo[0] = 8'h0F;
    run_frame(1);

    // Reset mid-byte with SS held low, then a clean frame.
    @(negedge clk);
    ss = 1'b0;
    void'(slot_byte());
    spi_bits(8'hC3, 3, mi);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_t", io1_t, 1'b1);
    check("mid_rst_o", io1_o, 1'b0);
    check("mid_rst_ready", spi_tx_ready, 1'b0);
    check("mid_rst_valid", spi_rx_valid, 1'b0);
    check("mid_rst_rxdata", spi_rx_data, 8'h00);
    exp_q.delete();
    rx_got.delete();
    rst = 1'b0;
    #1;
    check("mid_rst_ready1", spi_tx_ready, 1'b1);
    spi_bits(8'hC3, 5, mi);
    repeat (4) @(negedge clk);
    check("rst_ss_low_no_rx", rx_got.size(), 0);
    check("rst_ss_low_t", io1_t, 1'b1);
    rx_got.delete();
    ss = 1'b1;
    repeat (12) @(negedge clk);
    clear_frame();
    frame_mo[0] = 8'hC3;
    run_frame(1);

    // Randomized frames.
    for (int f = 0; f < 16; f++) begin
      clear_frame();
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) frame_mo[k] = 8'($urandom);
      for (int k = 0; k <= nb; k++) begin
        frame_push[k] = ($urandom_range(0, 1) == 1);
        frame_pv[k]   = 8'($urandom);
      end
      run_frame(nb);
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    rx_got.delete();
    repeat (12) @(negedge clk);
    check("ovr_clear", rx_overrun, 1'b0);
    clear_frame();
    frame_mo[0] = 8'h12;
    run_frame(1);
    check("ovr_first", rx_overrun, 1'b0);
    frame_mo[0] = 8'h34;
    run_frame(1);
    check("ovr_second", rx_overrun, 1'b1);
    push_byte(8'h77);
    repeat (40) @(negedge clk);
    check("ovr_sticky", rx_overrun, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ovr_rst", rx_overrun, 1'b0);
    rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
